rv_dp: RTL and testbench

- Datapath of the simple multicycle RISC-V core, the counterpart of the control plane (rv_ctl).
- Consumes rv_ctl's per-cycle control strobes; returns the current instruction and the ALU zero flag.
- Holds PC, PCC, IR, A/B, ALUOUT, MDR and the register file.
- Drives a Harvard memory pair: asynchronous-read instruction port, data port whose write strobe memrw comes from rv_ctl.

---
 rtl/rv_dp.sv | 95 +++++++++
 tb/tb_rv_dp.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dp.sv
// rv_dp: multicycle RISC-V datapath (PC, IR, operand latches, ALU, register file) sequenced by rv_ctl strobes
module rv_dp #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr,
    output logic        zero,
    input  logic        pcsourse,
    input  logic        pcwrite,
    input  logic        pccen,
    input  logic        irwrite,
    input  logic [1:0]  wbsel,
    input  logic        regwen,
    input  logic [1:0]  immsel,
    input  logic        asel,
    input  logic        bsel,
    input  logic [3:0]  alusel,
    input  logic        mdrwrite,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);
    logic [31:0] pc, pcc, ir, a, b, aluout, mdr;
    logic [31:0] rf [32];
    logic [31:0] rd1, rd2, imm, op_a, op_b, alu_r, wb, pc_next;
    logic [4:0]  sh;

    assign rd1 = ir[19:15] == 5'd0 ? 32'd0 : rf[ir[19:15]];
    assign rd2 = ir[24:20] == 5'd0 ? 32'd0 : rf[ir[24:20]];

    assign imm = immsel == 2'd0 ? {{20{ir[31]}}, ir[31:20]}
               : immsel == 2'd1 ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
               : immsel == 2'd2 ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
               : {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign op_a = asel ? pcc : a;
    assign op_b = bsel ? imm : b;
    assign sh   = op_b[4:0];

    always_comb begin
        alu_r = 32'd0;
        case (alusel)
            4'b0000: alu_r = op_a + op_b;
            4'b0001: alu_r = op_a - op_b;
            4'b0010: alu_r = op_a << sh;
            4'b0100: alu_r = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b0110: alu_r = {31'd0, op_a < op_b};
            4'b1000: alu_r = op_a ^ op_b;
            4'b1010: alu_r = op_a >> sh;
            4'b1011: alu_r = $unsigned($signed(op_a) >>> sh);
            4'b1100: alu_r = op_a | op_b;
            4'b1110: alu_r = op_a & op_b;
            default: alu_r = 32'd0;
        endcase
    end

    // JAL resolves its target in the same cycle; branches reuse the target latched during decode
    assign pc_next = pcsourse ? (asel ? alu_r : aluout) : pc + 32'd4;

    assign wb = wbsel == 2'd0 ? pc
              : wbsel == 2'd1 ? aluout
              : wbsel == 2'd2 ? mdr
              : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            pcc    <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            a      <= rd1;
            b      <= rd2;
            aluout <= alu_r;
            if (pcwrite) pc <= pc_next;
            if (pccen) pcc <= pc;
            if (irwrite) ir <= imem_rdata;
            if (mdrwrite) mdr <= dmem_rdata;
            if (regwen && ir[11:7] != 5'd0) rf[ir[11:7]] <= wb;
        end
    end

    assign instr      = ir;
    assign zero       = alu_r == 32'd0;
    assign imem_addr  = pc;
    assign dmem_addr  = aluout;
    assign dmem_wdata = b;
endmodule

// File: tb/tb_rv_dp.sv
// tb_rv_dp: drives rv_dp through instruction-level sequences and checks against an ISA-level model
module tb_rv_dp;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite;
    logic [1:0]  wbsel, immsel;
    logic [3:0]  alusel;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] m_pc;
    logic [31:0] m_rf [32];

    rv_dp dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .pcsourse(pcsourse),
        .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite), .wbsel(wbsel),
        .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel), .alusel(alusel),
        .mdrwrite(mdrwrite), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pcsourse = 0; pcwrite = 0; pccen = 0; irwrite = 0; wbsel = 0; regwen = 0;
        immsel = 0; asel = 0; bsel = 0; alusel = 0; mdrwrite = 0;
    endtask

    // RV32I register-register semantics
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int unsigned s;
        s = y[4:0];
        case (op)
            4'b0000: return x + y;
            4'b0001: return x + (~y + 1);
            4'b0010: return x * (32'd1 << s);
            4'b0100: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0110: return (x < y) ? 32'd1 : 32'd0;
            4'b1000: return (x | y) & ~(x & y);
            4'b1010: return x / (32'd1 << s);
            4'b1011: return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'b1100: return x | y;
            4'b1110: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    // LW-style load of v into xr without moving PC
    task automatic set_reg(input int r, input logic [31:0] v);
        idle;
        imem_rdata = {20'd0, r[4:0], 7'h03};
        irwrite = 1; mdrwrite = 1; dmem_rdata = v;
        tick;
        idle; wbsel = 2; regwen = 1;
        tick;
        idle;
        if (r != 0) m_rf[r] = v;
    endtask

    // xr surfaces on dmem_wdata via the B latch
    task automatic read_reg(input int r, output logic [31:0] v);
        idle;
        imem_rdata = {7'd0, r[4:0], 13'd0, 7'h23};
        irwrite = 1;
        tick;
        idle;
        tick;
        v = dmem_wdata;
    endtask

    task automatic fetch(input logic [31:0] w);
        idle;
        imem_rdata = w; irwrite = 1; pccen = 1; pcwrite = 1;
        tick;
        idle;
        m_pc = m_pc + 4;
    endtask

    task automatic set_pc(input logic [31:0] v);
        set_reg(31, v);
        imem_rdata = 32'h000F_8067;
        irwrite = 1;
        tick;
        idle;
        tick;
        bsel = 1;
        tick;
        idle; pcwrite = 1; pcsourse = 1;
        tick;
        idle;
        m_pc = v;
    endtask

    task automatic rtype(input logic [3:0] op, input int rd, input int rs1, input int rs2, output logic z);
        fetch({1'b0, op[0], 5'd0, rs2[4:0], rs1[4:0], op[3:1], rd[4:0], 7'h33});
        tick;
        alusel = op;
        #1 z = zero;
        tick;
        idle; wbsel = 1; regwen = 1;
        tick;
        idle;
    endtask

    task automatic test_reset;
        idle; imem_rdata = 0; dmem_rdata = 0;
        rst = 1;
        tick;
        rst = 0;
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        n_cmp += 5;
        if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'd0); end
        if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 32'd0); end
        if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
        if (dmem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_daddr: got %h want 0", dmem_addr); end
        if (dmem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
    endtask

    task automatic test_lw;
        logic [31:0] v;
        fetch(32'h0080_2083);
        n_cmp++;
        if (instr !== 32'h0080_2083) begin n_fail++; $display("FAIL lw_instr: got %h want %h", instr, 32'h0080_2083); end
        tick;
        immsel = 0; bsel = 1;
        tick;
        idle; mdrwrite = 1; dmem_rdata = 32'h1234;
        n_cmp++;
        if (dmem_addr !== 32'd8) begin n_fail++; $display("FAIL lw_daddr: got %h want %h", dmem_addr, 32'd8); end
        tick;
        idle; wbsel = 2; regwen = 1;
        tick;
        idle;
        m_rf[1] = 32'h1234;
        n_cmp++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL lw_pc: got %h want %h", imem_addr, m_pc); end
        read_reg(1, v);
        n_cmp++;
        if (v !== 32'h1234) begin n_fail++; $display("FAIL lw_x1: got %h want %h", v, 32'h1234); end
    endtask

    task automatic test_sub_sra;
        logic z;
        logic [31:0] v;
        set_reg(1, 5); set_reg(2, 7); set_reg(5, 1);
        rtype(4'b0001, 3, 1, 2, z);
        n_cmp++;
        if (z !== 1'b0) begin n_fail++; $display("FAIL sub_zero: got %b want 0", z); end
        rtype(4'b1011, 4, 3, 5, z);
        n_cmp++;
        if (z !== 1'b0) begin n_fail++; $display("FAIL sra_zero: got %b want 0", z); end
        read_reg(3, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_x3: got %h want %h", v, 32'hFFFF_FFFE); end
        read_reg(4, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_x4: got %h want %h", v, 32'hFFFF_FFFF); end
        m_rf[3] = 32'hFFFF_FFFE; m_rf[4] = 32'hFFFF_FFFF;
    endtask

    task automatic test_branch(input bit eq);
        logic [31:0] va;
        va = $urandom;
        set_reg(1, va);
        set_reg(2, eq ? va : va + 1);
        set_pc(32'h10);
        fetch({1'b0, 6'd0, 5'd2, 5'd1, 3'd0, 4'b0100, 1'b0, 7'h63});
        asel = 1; bsel = 1; immsel = 2;
        tick;
        idle; alusel = 4'b0001;
        #1;
        n_cmp++;
        if (zero !== eq) begin n_fail++; $display("FAIL beq_zero(eq=%0d): got %b want %b", eq, zero, eq); end
        pcwrite = eq; pcsourse = 1;
        tick;
        idle;
        if (eq) m_pc = 32'h18;
        n_cmp++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL beq_pc(eq=%0d): got %h want %h", eq, imem_addr, m_pc); end
    endtask

    task automatic test_jal;
        logic [31:0] v;
        set_pc(32'h20);
        fetch({1'b0, 10'h080, 1'b0, 8'h00, 5'd1, 7'h6f});
        tick;
        asel = 1; bsel = 1; immsel = 3; pcsourse = 1; pcwrite = 1; wbsel = 0; regwen = 1;
        tick;
        idle;
        m_pc = 32'h20 + 32'h100;
        m_rf[1] = 32'h24;
        n_cmp++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL jal_pc: got %h want %h", imem_addr, m_pc); end
        read_reg(1, v);
        n_cmp++;
        if (v !== m_rf[1]) begin n_fail++; $display("FAIL jal_link: got %h want %h", v, m_rf[1]); end
    endtask

    task automatic test_x0_wrap;
        logic z;
        logic [31:0] v;
        set_reg(1, $urandom | 32'd1);
        rtype(4'b0000, 0, 1, 1, z);
        read_reg(0, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL x0_add: got %h want 0", v); end
        set_reg(0, 32'hDEAD_BEEF);
        read_reg(0, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL x0_load: got %h want 0", v); end
        set_pc(32'hFFFF_FFFC);
        pcwrite = 1;
        tick;
        idle;
        m_pc = m_pc + 4;
        n_cmp++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", imem_addr, m_pc); end
    endtask

    task automatic test_rw_same;
        logic [31:0] old_v, new_v, v;
        old_v = $urandom; new_v = ~old_v;
        set_reg(9, old_v);
        imem_rdata = {7'd0, 5'd9, 5'd0, 3'd0, 5'd9, 7'h33};
        irwrite = 1; mdrwrite = 1; dmem_rdata = new_v;
        tick;
        idle; wbsel = 2; regwen = 1;
        tick;
        idle;
        n_cmp++;
        if (dmem_wdata !== old_v) begin n_fail++; $display("FAIL rw_old: got %h want %h", dmem_wdata, old_v); end
        tick;
        m_rf[9] = new_v;
        n_cmp++;
        if (dmem_wdata !== new_v) begin n_fail++; $display("FAIL rw_new: got %h want %h", dmem_wdata, new_v); end
        imem_rdata = {7'd0, 5'd9, 5'd0, 3'd0, 5'd9, 7'h33};
        irwrite = 1;
        tick;
        idle; wbsel = 3; regwen = 1;
        tick;
        idle;
        m_rf[9] = 0;
        read_reg(9, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL wb_reserved: got %h want 0", v); end
    endtask

    task automatic test_random;
        logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b1000,
                                 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b0011, 4'b1111};
        logic [31:0] va, vb, res, v;
        logic [3:0] op;
        logic z;
        int rd, rs1, rs2;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 11)];
            rd = $urandom_range(1, 31); rs1 = $urandom_range(1, 31); rs2 = $urandom_range(1, 31);
            va = $urandom;
            vb = ($urandom_range(0, 3) == 0) ? va : $urandom;
            set_reg(rs1, va);
            set_reg(rs2, vb);
            res = alu_ref(op, m_rf[rs1], m_rf[rs2]);
            rtype(op, rd, rs1, rs2, z);
            m_rf[rd] = res;
            n_cmp++;
            if (z !== (res == 0)) begin n_fail++; $display("FAIL rand_zero op=%b: got %b want %b", op, z, res == 0); end
            n_cmp++;
            if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rand_pc: got %h want %h", imem_addr, m_pc); end
            read_reg(rd, v);
            n_cmp++;
            if (v !== m_rf[rd]) begin n_fail++; $display("FAIL rand_rd op=%b a=%h b=%h: got %h want %h", op, va, vb, v, m_rf[rd]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        set_reg(7, 32'h55AA_55AA);
        set_pc(32'h40);
        fetch(32'h0073_8233);
        #2 rst = 1;
        #1;
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        n_cmp += 5;
        if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_pc: got %h want 0", imem_addr); end
        if (instr !== 32'd0) begin n_fail++; $display("FAIL rstmid_instr: got %h want 0", instr); end
        if (zero !== 1'b1) begin n_fail++; $display("FAIL rstmid_zero: got %b want 1", zero); end
        if (dmem_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_daddr: got %h want 0", dmem_addr); end
        if (dmem_wdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_wdata: got %h want 0", dmem_wdata); end
        tick;
        n_cmp++;
        if (zero !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_held: got zero=%b pc=%h want zero=1 pc=0", zero, imem_addr); end
        rst = 0;
        for (int r = 1; r < 32; r++) begin
            read_reg(r, v);
            n_cmp++;
            if (v !== m_rf[r]) begin n_fail++; $display("FAIL rstmid_x%0d: got %h want %h", r, v, m_rf[r]); end
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sub_sra;
        test_branch(1);
        test_branch(0);
        test_jal;
        test_x0_wrap;
        test_rw_same;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
